exu_alu_seq: RTL and testbench

EXU_ALU_SEQ -- requirements
Module: exu_alu_seq

---
 rtl/exu_pkg.sv | 35 +++
 rtl/exu_alu_seq.sv | 178 +++++++++++++++++
 tb/tb_exu_alu_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_pkg.sv
// ============================================================================
// Package     : exu_pkg
// Description : Shared types and constants for the sequential ALU/multiply
//               execution unit: FSM state encoding and the select codes
//               understood by the external shared combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exu_pkg;

  // Control FSM states of exu_alu_seq
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } exu_state_t;

  // Select codes of the shared ALU. The multiply datapath only relies on ADD;
  // the rest are passed through unchanged for single-cycle operations.
  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OP_AND  = 4'b0010;
  localparam logic [3:0] ALU_OP_OR   = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0101;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
  localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLT  = 4'b1000;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1001;

endpackage : exu_pkg

`default_nettype wire

// File: rtl/exu_alu_seq.sv
// ============================================================================
// Module      : exu_alu_seq
// Description : Sequential execution unit in front of a shared, external
//               combinational ALU. Single-cycle ALU ops pass through one EXEC
//               cycle; multiplies are computed shift-and-add, one partial
//               product per cycle, using the external ALU as the adder.
//               Results are held in DONE until the downstream accepts them.
// Revision    : 1.0 - initial release
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      upstream operation valid
//   in_ready    out  1      unit can accept an operation (IDLE only)
//   in_aluop    in   4      ALU select for single-cycle ops
//   in_mul      in   1      1 = multiply (low WIDTH bits), in_aluop ignored
//   in_src1     in   WIDTH  operand 1 / multiplicand
//   in_src2     in   WIDTH  operand 2 / multiplier
//   flush       in   1      synchronous abort of the operation in flight
//   alu_a       out  WIDTH  shared ALU operand A
//   alu_b       out  WIDTH  shared ALU operand B
//   alu_sel     out  4      shared ALU select
//   alu_res     in   WIDTH  shared ALU result (combinational)
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_result  out  WIDTH  registered result
// ============================================================================
`default_nettype none

module exu_alu_seq
  import exu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic             in_mul,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  // A single-iteration multiplier still needs a 1-bit counter.
  localparam int             CNT_W    = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  exu_state_t        r_state;
  exu_state_t        w_state_nxt;

  // Goes high on the first clock edge after reset release; keeps the unit
  // from accepting on the edge where rst_n rises.
  logic              r_live;

  logic [3:0]        r_op;
  // r_opa holds src1 for EXEC and doubles as the shifting multiplicand in MUL;
  // r_opb holds src2 for EXEC and doubles as the shifting multiplier in MUL.
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_result;

  logic              w_accept;
  logic [WIDTH-1:0]  w_mplier_nxt;
  logic              w_mul_last;

  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_mplier_nxt = r_opb >> 1;
  // Stop early once no multiplier bits remain, or after MUL_ITER iterations.
  assign w_mul_last   = (w_mplier_nxt == '0) || (r_cnt == CNT_LAST);
  assign out_result   = r_result;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; flush overrides everything including handoff.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = in_mul ? ST_MUL : ST_EXEC;
        ST_EXEC: w_state_nxt = ST_DONE;
        ST_MUL:  if (w_mul_last) w_state_nxt = ST_DONE;
        ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = ALU_OP_ADD;
    case (r_state)
      ST_IDLE: in_ready = r_live;
      ST_EXEC: begin
        alu_a   = r_opa;
        alu_b   = r_opb;
        alu_sel = r_op;
      end
      ST_MUL: begin
        // Partial product: multiplicand gated by the current multiplier LSB.
        alu_a   = r_acc;
        alu_b   = r_opa & {WIDTH{r_opb[0]}};
        alu_sel = ALU_OP_ADD;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand / multiply datapath and result register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_op  <= in_aluop;
        r_opa <= in_src1;
        r_opb <= in_src2;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (!flush) begin
        case (r_state)
          ST_EXEC: r_result <= alu_res;
          ST_MUL: begin
            r_acc <= alu_res;
            r_opa <= r_opa << 1;
            r_opb <= w_mplier_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_mul_last) r_result <= alu_res;
          end
          default: ;
        endcase
      end
    end
  end

endmodule : exu_alu_seq

`default_nettype wire

// File: tb/tb_exu_alu_seq.sv
// ============================================================================
// Module      : tb_exu_alu_seq
// Description : Self-checking bench for exu_alu_seq with a behavioural model
//               of the shared combinational ALU. Table-driven single ops and
//               multiplies, plus hand sequences for back-pressure, flush and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exu_alu_seq;
  import exu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_aluop;
  logic             in_mul;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             flush;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  int checks = 0;
  int errors = 0;

  exu_alu_seq #(.WIDTH(WIDTH), .MUL_ITER(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_mul     (in_mul),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU model
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_OP_ADD: alu_res = alu_a + alu_b;
      ALU_OP_SUB: alu_res = alu_a - alu_b;
      ALU_OP_AND: alu_res = alu_a & alu_b;
      ALU_OP_OR:  alu_res = alu_a | alu_b;
      ALU_OP_XOR: alu_res = alu_a ^ alu_b;
      ALU_OP_SLL: alu_res = alu_a << alu_b[4:0];
      ALU_OP_SRL: alu_res = alu_a >> alu_b[4:0];
      default:    alu_res = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE, count busy cycles until out_valid,
  // capture the result, then hand it off.
  task automatic do_op(input logic m, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int cyc);
    @(negedge clk);
    in_valid = 1'b1;
    in_mul   = m;
    in_aluop = op;
    in_src1  = a;
    in_src2  = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    res = out_result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] res;
    int          cyc;
    int          bad;

    // m, op, src1, src2, expected result, busy cycles (EXEC=1, else MUL cycles)
    vecs[0]  = '{1'b0, ALU_OP_ADD, 32'd5,        32'd7,        32'd12,       1};
    vecs[1]  = '{1'b0, ALU_OP_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 1};
    vecs[2]  = '{1'b0, ALU_OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vecs[3]  = '{1'b0, ALU_OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};
    vecs[4]  = '{1'b0, ALU_OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
    vecs[5]  = '{1'b0, ALU_OP_SLL, 32'd1,        32'd4,        32'd16,       1};
    // Multiplies use aluop=SUB to show it is ignored
    vecs[6]  = '{1'b1, ALU_OP_SUB, 32'd3,        32'd4,        32'd12,       3};
    vecs[7]  = '{1'b1, ALU_OP_SUB, 32'h1234,     32'd0,        32'd0,        1};
    vecs[8]  = '{1'b1, ALU_OP_SUB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32};
    vecs[9]  = '{1'b1, ALU_OP_SUB, 32'd7,        32'd1,        32'd7,        1};
    vecs[10] = '{1'b1, ALU_OP_SUB, 32'h00010000, 32'h00010000, 32'd0,        17};
    vecs[11] = '{1'b1, ALU_OP_SUB, 32'd6,        32'd5,        32'd30,       3};
    vecs[12] = '{1'b1, ALU_OP_SUB, 32'h80000000, 32'd2,        32'd0,        2};

    rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; in_mul = 1'b0;
    in_src1 = '0; in_src2 = '0; flush = 1'b0; out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);

    // ---------------- add 5+7 with out_ready held high ----------------
    out_ready = 1'b1;
    in_valid = 1'b1; in_mul = 1'b0; in_aluop = ALU_OP_ADD; in_src1 = 32'd5; in_src2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_exec_in_ready", {31'd0, in_ready}, 32'd0);
    chk("add_exec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("add_exec_alu_a", alu_a, 32'd5);
    chk("add_exec_alu_b", alu_b, 32'd7);
    @(negedge clk);
    chk("add_done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_done_result", out_result, 32'd12);
    chk("add_done_in_ready", {31'd0, in_ready}, 32'd0);
    chk("add_done_alu_a", alu_a, 32'd0);
    @(negedge clk);
    chk("add_after_in_ready", {31'd0, in_ready}, 32'd1);
    chk("add_after_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].m, vecs[i].op, vecs[i].a, vecs[i].b, res, cyc);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("vec%0d_ready_after", i), {31'd0, in_ready}, 32'd1);
    end

    // ---------------- back-pressure in DONE ----------------
    @(negedge clk);
    in_valid = 1'b1; in_mul = 1'b1; in_src1 = 32'd9; in_src2 = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin cyc++; @(negedge clk); end
    chk("stall_mul_cycles", cyc, 4);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || out_result !== 32'd81 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("stall_stable", bad, 0);
    chk("stall_6th_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_6th_result", out_result, 32'd81);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_after_in_ready", {31'd0, in_ready}, 32'd1);
    chk("stall_after_out_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- flush in MUL cycle 10 ----------------
    do_op(1'b0, ALU_OP_ADD, 32'd100, 32'd23, res, cyc);
    chk("pre_flush_result", res, 32'd123);
    @(negedge clk);
    in_valid = 1'b1; in_mul = 1'b1; in_src1 = 32'hFFFFFFFF; in_src2 = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_in_mul_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    in_valid = 1'b1; in_mul = 1'b0; in_aluop = ALU_OP_ADD; in_src1 = 32'd1; in_src2 = 32'd1;
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_result_kept", out_result, 32'd123);
    chk("flush_alu_a", alu_a, 32'd0);
    @(negedge clk);
    chk("flush_hold_no_accept", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_flush_accept", {31'd0, in_ready}, 32'd0);
    chk("post_flush_alu_a", alu_a, 32'd1);
    @(negedge clk);
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_result", out_result, 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // ---------------- reset during EXEC ----------------
    in_valid = 1'b1; in_mul = 1'b0; in_aluop = ALU_OP_ADD; in_src1 = 32'd5; in_src2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rexec_alu_a", alu_a, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rexec_alu_a_zero", alu_a, 32'd0);
    chk("rexec_alu_b_zero", alu_b, 32'd0);
    chk("rexec_alu_sel_zero", {28'd0, alu_sel}, 32'd0);
    chk("rexec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rexec_out_result", out_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rexec_in_ready_after", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("rexec_no_result", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_exu_alu_seq

`default_nettype wire
